pc_gen: RTL and testbench

//   Parametrised program-counter generator for the fetch stage; successor to the fixed 32-bit PC register.

---
 rtl/pc_gen.sv | 89 ++++++++
 tb/tb_pc_gen.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch-stage program counter with prioritised redirects and an exception PC.
// A redirect that arrives during a stall is parked and applied once the stall releases.
module pc_gen #(
  parameter int unsigned WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h00003000,
  parameter logic [31:0] EXC_VECTOR   = 32'h00004180,
  parameter int unsigned STEP         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc_req,
  input  logic [WIDTH-1:0] exc_epc,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] epc,
  output logic             pend_valid,
  output logic             misaligned
);

  localparam logic [WIDTH-1:0] RST_PC    = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] EXC_PC    = WIDTH'(EXC_VECTOR);
  localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MSK = WIDTH'(STEP - 1);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;

  assign pc         = pc_q;
  assign pc_plus    = pc_q + STEP_W;
  assign epc        = epc_q;
  assign pend_valid = (state_q == HOLD);
  assign misaligned = |(pc_q & ALIGN_MSK);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    epc_d         = epc_q;
    pend_target_d = pend_target_q;
    if (reset) begin
      state_d       = RUN;
      pc_d          = RST_PC;
      epc_d         = '0;
      pend_target_d = '0;
    end else if (exc_req) begin
      state_d = RUN;
      pc_d    = EXC_PC;
      epc_d   = exc_epc;
    end else if (stall) begin
      // Only the first redirect seen during a stall is kept.
      if (state_q == RUN) begin
        if (eret) begin
          pend_target_d = epc_q;
          state_d       = HOLD;
        end else if (br_valid) begin
          pend_target_d = br_target;
          state_d       = HOLD;
        end
      end
    end else if (state_q == HOLD) begin
      pc_d    = pend_target_q;
      state_d = RUN;
    end else if (eret) begin
      pc_d = epc_q;
    end else if (br_valid) begin
      pc_d = br_target;
    end else begin
      pc_d = pc_plus;
    end
  end

  always_ff @(posedge clk) begin
    state_q       <= state_d;
    pc_q          <= pc_d;
    epc_q         <= epc_d;
    pend_target_q <= pend_target_d;
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a 32-bit default instance and a 16-bit instance exercising wrap.
// Expected values are queued with the cycle they fall due and checked by a separate monitor.
module tb_pc_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        reset, stall, br_valid, exc_req, eret;
  logic [31:0] br_target, exc_epc;
  logic [31:0] pc, pc_plus, epc;
  logic        pend_valid, misaligned;

  // 16-bit instance
  logic        s_reset, s_stall, s_br_valid, s_exc_req, s_eret;
  logic [15:0] s_br_target, s_exc_epc;
  logic [15:0] s_pc, s_pc_plus, s_epc;
  logic        s_pend_valid, s_misaligned;

  pc_gen dut (
    .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid), .br_target(br_target),
    .exc_req(exc_req), .exc_epc(exc_epc), .eret(eret), .pc(pc), .pc_plus(pc_plus),
    .epc(epc), .pend_valid(pend_valid), .misaligned(misaligned)
  );

  pc_gen #(.WIDTH(16), .RESET_VECTOR(32'h0000FFF8)) dut16 (
    .clk(clk), .reset(s_reset), .stall(s_stall), .br_valid(s_br_valid), .br_target(s_br_target),
    .exc_req(s_exc_req), .exc_epc(s_exc_epc), .eret(s_eret), .pc(s_pc), .pc_plus(s_pc_plus),
    .epc(s_epc), .pend_valid(s_pend_valid), .misaligned(s_misaligned)
  );

  typedef struct {
    int unsigned due;
    bit          sel16;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        pend;
    logic        mis;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc   = 0;
  int          total = 0;
  int          bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Monitor: pops every expectation whose due cycle has been reached.
  initial begin
    exp_t e;
    logic [31:0] mask;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check({e.name, "/late"}, cyc, e.due);
        mask = e.sel16 ? 32'h0000FFFF : 32'hFFFFFFFF;
        if (e.sel16) begin
          check({e.name, "/pc"},      {16'h0, s_pc},      e.pc);
          check({e.name, "/pc_plus"}, {16'h0, s_pc_plus}, (e.pc + 32'd4) & mask);
          check({e.name, "/epc"},     {16'h0, s_epc},     e.epc);
          check({e.name, "/pend"},    {31'h0, s_pend_valid}, {31'h0, e.pend});
          check({e.name, "/mis"},     {31'h0, s_misaligned}, {31'h0, e.mis});
        end else begin
          check({e.name, "/pc"},      pc,      e.pc);
          check({e.name, "/pc_plus"}, pc_plus, (e.pc + 32'd4) & mask);
          check({e.name, "/epc"},     epc,     e.epc);
          check({e.name, "/pend"},    {31'h0, pend_valid}, {31'h0, e.pend});
          check({e.name, "/mis"},     {31'h0, misaligned}, {31'h0, e.mis});
        end
      end
    end
  end

  // Drive one cycle of inputs and queue the state expected after the next posedge.
  task automatic drive(input bit sel16, input bit rs, input bit st, input bit bv,
                       input logic [31:0] bt, input bit ex, input logic [31:0] ee, input bit er,
                       input logic [31:0] xpc, input logic [31:0] xepc, input bit xpend,
                       input bit xmis, input string nm);
    exp_t e;
    if (sel16) begin
      s_reset = rs; s_stall = st; s_br_valid = bv; s_br_target = bt[15:0];
      s_exc_req = ex; s_exc_epc = ee[15:0]; s_eret = er;
    end else begin
      reset = rs; stall = st; br_valid = bv; br_target = bt;
      exc_req = ex; exc_epc = ee; eret = er;
    end
    e.due = cyc + 1; e.sel16 = sel16; e.pc = xpc; e.epc = xepc;
    e.pend = xpend; e.mis = xmis; e.name = nm;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; stall = 0; br_valid = 0; br_target = '0; exc_req = 0; exc_epc = '0; eret = 0;
    s_reset = 1'b1; s_stall = 0; s_br_valid = 0; s_br_target = '0; s_exc_req = 0; s_exc_epc = '0; s_eret = 0;
    @(posedge clk); #1;
    //    sel rs st bv bt            ex ee            er  pc            epc           pd mis name
    drive(0, 1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h00003000, 32'h0,       0, 0, "t1_rst0");
    drive(0, 1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h00003000, 32'h0,       0, 0, "t1_rst1");
    drive(0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h00003004, 32'h0,       0, 0, "t1_seq0");
    drive(0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h00003008, 32'h0,       0, 0, "t1_seq1");
    drive(0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0000300C, 32'h0,       0, 0, "t1_seq2");
    drive(0, 0, 1, 1, 32'h3100,    0, 32'h0,       0, 32'h0000300C, 32'h0,       1, 0, "t2_pend");
    drive(0, 0, 1, 0, 32'h0,       0, 32'h0,       0, 32'h0000300C, 32'h0,       1, 0, "t2_hold");
    drive(0, 0, 1, 1, 32'h3200,    0, 32'h0,       0, 32'h0000300C, 32'h0,       1, 0, "t2_ignore");
    drive(0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h00003100, 32'h0,       0, 0, "t2_apply");
    drive(0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h00003104, 32'h0,       0, 0, "t2_seq");
    drive(0, 0, 1, 1, 32'h3300,    0, 32'h0,       0, 32'h00003104, 32'h0,       1, 0, "t2b_pend");
    drive(0, 0, 0, 1, 32'h3500,    0, 32'h0,       0, 32'h00003300, 32'h0,       0, 0, "t2b_drop");
    drive(0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h00003304, 32'h0,       0, 0, "t2b_seq");
    drive(0, 0, 1, 1, 32'h3400,    0, 32'h0,       0, 32'h00003304, 32'h0,       1, 0, "t3_pend");
    drive(0, 0, 1, 0, 32'h0,       1, 32'h3020,    0, 32'h00004180, 32'h3020,    0, 0, "t3_exc");
    drive(0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h00004184, 32'h3020,    0, 0, "t3_seq");
    drive(0, 0, 0, 0, 32'h0,       0, 32'h0,       1, 32'h00003020, 32'h3020,    0, 0, "t3_eret");
    drive(0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h00003024, 32'h3020,    0, 0, "t3_seq2");
    drive(0, 0, 0, 0, 32'h0,       1, 32'h3010,    0, 32'h00004180, 32'h3010,    0, 0, "t4_exc0");
    drive(0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h00004184, 32'h3010,    0, 0, "t4_seq");
    drive(0, 0, 0, 0, 32'h0,       1, 32'h3040,    1, 32'h00004180, 32'h3040,    0, 0, "t4_exc_eret");
    drive(0, 0, 0, 0, 32'h0,       0, 32'h0,       1, 32'h00003040, 32'h3040,    0, 0, "t4_eret");
    drive(0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h00003044, 32'h3040,    0, 0, "t4_seq2");
    drive(0, 0, 1, 0, 32'h0,       0, 32'h0,       1, 32'h00003044, 32'h3040,    1, 0, "eret_pend");
    drive(0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h00003040, 32'h3040,    0, 0, "eret_apply");
    drive(0, 0, 0, 1, 32'h3200,    0, 32'h0,       0, 32'h00003200, 32'h3040,    0, 0, "br");
    drive(0, 0, 0, 1, 32'h3300,    0, 32'h0,       1, 32'h00003040, 32'h3040,    0, 0, "eret_over_br");
    drive(0, 0, 0, 1, 32'h3006,    0, 32'h0,       0, 32'h00003006, 32'h3040,    0, 1, "br_misal");
    drive(0, 0, 1, 1, 32'h3600,    0, 32'h0,       0, 32'h00003006, 32'h3040,    1, 1, "t6_pend");
    drive(0, 1, 1, 1, 32'h3700,    1, 32'h3050,    0, 32'h00003000, 32'h0,       0, 0, "t6_rst");
    drive(0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h00003004, 32'h0,       0, 0, "t6_seq");
    drive(1, 1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0000FFF8, 32'h0,       0, 0, "t5_rst");
    drive(1, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0000FFFC, 32'h0,       0, 0, "t5_seq");
    drive(1, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h00000000, 32'h0,       0, 0, "t5_wrap");
    drive(1, 0, 0, 1, 32'h0006,    0, 32'h0,       0, 32'h00000006, 32'h0,       0, 1, "t5_misal");
    drive(1, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0000000A, 32'h0,       0, 1, "t5_misal_seq");
    drive(1, 0, 0, 0, 32'h0,       1, 32'h1234,    0, 32'h00004180, 32'h1234,    0, 0, "t5_exc");
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
